i2c_master_controller: RTL and testbench
========================================

# i2c_master_controller

- Single-byte I2C master that generates START, 7-bit address + R/W, one data byte (write or read), and STOP on an open-drain `sda`/`scl` pair.
- Pairs with the team's I2C slave controller on the same bus and is the initiator side of that protocol.
- Clocked from the system clock; SCL is derived by an internal divider.
- No clock stretching, no multi-master arbitration, no repeated START.

## Interface
Parameters:
- `DIV`, default 250: system clocks per SCL quarter-period (SCL period = 4·DIV clocks); legal range ≥ 2.

Ports:
- `clk` input, 1: system clock; all logic on its rising edge.
- `rst_n` input, 1: asynchronous active-low reset.
- `start` input, 1: transaction request; sampled only when `busy`=0.
- `addr` input, 7: target address; captured on an accepted `start`.
- `rw` input, 1: 0 = write `wdata`, 1 = read one byte; captured on an accepted `start`.
- `wdata` input, 8: write byte; captured on an accepted `start`.
- `rdata` output, 8: last byte read; updated only by a completed read.
- `busy` output, 1: high from the cycle after start acceptance until `done`.
- `done` output, 1: one-clock pulse at transaction end.
- `ack_err` output, 1: valid with `done`, held until the next accept; 1 = address or write-data NACK.
- `sda` inout, 1: open-drain; driven 0 or released to Z only, never driven 1.
- `scl` inout, 1: open-drain; driven 0 or Z only.

## Operation
- Reset values:
  - state IDLE; `busy`=0, `done`=0, `ack_err`=0, `rdata`=8'h00.
  - `sda` and `scl` released (Z); quarter and bit counters 0.
- Reset mid-transaction releases both lines in the same cycle as the reset assertion and abandons the transfer. No STOP is generated.
- Every bit takes 4 quarters, q0..q3, each DIV clocks long:
  - SCL is low in q0–q1 and released in q2–q3.
  - SDA changes only on the first clock of q0.
  - SDA is sampled on the last clock of q2.
- State sequence: IDLE → START → ADDR (8 bits, MSB first, `{addr,rw}`) → ADDR_ACK → WRITE/READ (8 bits, MSB first) → DATA_ACK → STOP → IDLE.
- START:
  - q0–q1: SDA released, SCL released.
  - q2–q3: SDA low, SCL released.
  - The falling SDA edge occurs while SCL is high.
- ADDR_ACK:
  - SDA released; the slave's bit is sampled.
  - Sampled 1: set `ack_err` and go directly to STOP, skipping the data phase.
- WRITE: drive `wdata` bits. DATA_ACK samples the slave's ACK; a NACK sets `ack_err`.
- READ:
  - SDA is released; bits are shifted into a register.
  - `rdata` loads on the last clock of DATA_ACK.
  - In DATA_ACK the master releases SDA (NACK = 1), ending the read.
- STOP:
  - q0–q1: SCL low, SDA low.
  - q2: SCL released, SDA low.
  - q3: SDA released, so SDA rises while SCL is high.
- A `start` received while busy is ignored; it is not queued.
- A `start` in the same cycle as the `done` pulse is ignored.
- A `start` on the first IDLE cycle after `done` is accepted.

## Timing
- `start` is sampled high in cycle 0. `busy`=1 from cycle 1.
- Full transaction: 20 bit-slots (START + 9 address/ACK + 9 data/ACK + STOP) = 80·DIV clocks.
  - `done` pulses in cycle 80·DIV + 1.
  - `busy` falls in the same cycle as `done`.
- Address NACK: 11 bit-slots, `done` in cycle 44·DIV + 1.
- SCL is high for exactly 2·DIV clocks per data bit (50 % duty).

## Structure
- Package `i2c_pkg`:
  - State enum `i2c_mstate_t` (IDLE, START, ADDR, ADDR_ACK, WRITE, READ, DATA_ACK, STOP).
  - `I2C_RW_WRITE`=0 and `I2C_RW_READ`=1 constants.
  - Shared by master and slave benches.
- Sub-module `i2c_qtick`:
  - DIV-count divider emitting a one-clock `qtick` at the end of each quarter.
  - Plus a 2-bit quarter index.
  - Cleared while IDLE.
- The master FSM, shift register and bit counter form the top level.

## Test plan
- Write: `addr`=7'h2A, `rw`=0, `wdata`=8'hA5, slave model ACKs both bytes.
  - Bus shows byte 8'h54, then 8'hA5.
  - `done` at cycle 80·DIV+1, `ack_err`=0.
- Read: `addr`=7'h2A, `rw`=1; slave returns 8'hCC.
  - `rdata`=8'hCC at `done`; master leaves SDA released during the 9th data bit (NACK); `ack_err`=0.
- Address NACK: `addr`=7'h11, no slave responds.
  - `ack_err`=1, no data clocks issued, STOP seen, `done` at 44·DIV+1.
- Back-to-back: `start` held high continuously.
  - Second transaction accepted only on the first IDLE cycle after `done`.
  - The `start` during busy has no effect.
- Reset mid-ADDR: deassert `rst_n` during address bit 3.
  - `sda`/`scl` go to Z immediately; `busy`=0, `rdata` holds 8'h00.
  - Next `start` runs a clean full transaction.
- Protocol checker, run on all tests:
  - SDA never changes while SCL is high except at START and STOP.
  - The master never drives `sda` or `scl` to 1.

Source files
------------

// File: rtl/i2c_pkg.sv
// Shared I2C definitions: master state encoding, R/W constants and the
// per-quarter open-drain pull decode used by the master.
package i2c_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    START    = 3'd1,
    ADDR     = 3'd2,
    ADDR_ACK = 3'd3,
    WRITE    = 3'd4,
    READ     = 3'd5,
    DATA_ACK = 3'd6,
    STOP     = 3'd7
  } i2c_mstate_t;

  localparam logic I2C_RW_WRITE = 1'b0;
  localparam logic I2C_RW_READ  = 1'b1;

  localparam logic [1:0] Q0 = 2'd0;
  localparam logic [1:0] Q1 = 2'd1;
  localparam logic [1:0] Q2 = 2'd2;
  localparam logic [1:0] Q3 = 2'd3;

  // 1 = pull SCL low. SCL is only held low in q0-q1 of bus bits.
  function automatic logic scl_pull(input i2c_mstate_t st, input logic [1:0] q);
    logic pull;
    case (st)
      IDLE, START: pull = 1'b0;
      default:     pull = (q == Q0) || (q == Q1);
    endcase
    return pull;
  endfunction

  // 1 = pull SDA low. The START fall and STOP rise happen while SCL is high.
  function automatic logic sda_pull(input i2c_mstate_t st, input logic [1:0] q,
                                    input logic bit_val);
    logic pull;
    case (st)
      START:       pull = (q == Q2) || (q == Q3);
      ADDR, WRITE: pull = ~bit_val;
      STOP:        pull = (q != Q3);
      default:     pull = 1'b0;
    endcase
    return pull;
  endfunction

endpackage

// File: rtl/i2c_qtick.sv
// Quarter-period divider: DIV clocks per quarter, a one-clock qtick on the
// last clock of each quarter, and a 2-bit quarter index. Held clear when idle.
module i2c_qtick #(
  parameter int DIV = 250
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en_i,
  output logic       qtick_o,
  output logic [1:0] quarter_o,
  output logic [1:0] quarter_nx_o
);

  localparam int CW = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    quarter_q, quarter_d;
  logic          last_s;

  assign last_s       = (cnt_q == CNT_LAST);
  assign qtick_o      = en_i && last_s;
  assign quarter_o    = quarter_q;
  assign quarter_nx_o = quarter_d;

  always_comb begin
    cnt_d     = cnt_q;
    quarter_d = quarter_q;
    if (!en_i) begin
      cnt_d     = '0;
      quarter_d = 2'd0;
    end else if (last_s) begin
      cnt_d     = '0;
      quarter_d = quarter_q + 2'd1;
    end else begin
      cnt_d     = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      quarter_q <= 2'd0;
    end else begin
      cnt_q     <= cnt_d;
      quarter_q <= quarter_d;
    end
  end

endmodule

// File: rtl/i2c_master_controller.sv
// Single-byte I2C master: START, {addr,rw}, one data byte, STOP on an
// open-drain SDA/SCL pair. Line drives are registered from next-state decode.
module i2c_master_controller
  import i2c_pkg::*;
#(
  parameter int DIV = 250
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [6:0] addr,
  input  logic       rw,
  input  logic [7:0] wdata,
  output logic [7:0] rdata,
  output logic       busy,
  output logic       done,
  output logic       ack_err,
  inout  wire        sda,
  inout  wire        scl
);

  i2c_mstate_t state_q, state_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  sh_q, sh_d;
  logic        rw_q, rw_d;
  logic [7:0]  wdata_q, wdata_d;
  logic [7:0]  rdata_q, rdata_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        ack_err_q, ack_err_d;
  logic        sda_pull_q, sda_pull_d;
  logic        scl_pull_q, scl_pull_d;

  logic        qtick_s;
  logic [1:0]  quarter_s, quarter_nx_s;
  logic        accept_s, end_bit_s, sample_s, bit_last_s, sda_in_s;

  i2c_qtick #(.DIV(DIV)) u_qtick (
    .clk         (clk),
    .rst_n       (rst_n),
    .en_i        (state_q != IDLE),
    .qtick_o     (qtick_s),
    .quarter_o   (quarter_s),
    .quarter_nx_o(quarter_nx_s)
  );

  assign sda_in_s   = sda;
  // The done cycle is excluded so a held start waits one more IDLE cycle.
  assign accept_s   = (state_q == IDLE) && start && !busy_q && !done_q;
  assign end_bit_s  = qtick_s && (quarter_s == Q3);
  assign sample_s   = qtick_s && (quarter_s == Q2);
  assign bit_last_s = (bit_cnt_q == 3'd7);

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    sh_d      = sh_q;
    rw_d      = rw_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    ack_err_d = ack_err_q;
    case (state_q)
      IDLE: begin
        if (accept_s) begin
          state_d   = START;
          busy_d    = 1'b1;
          ack_err_d = 1'b0;
          sh_d      = {addr, rw};
          rw_d      = rw;
          wdata_d   = wdata;
          bit_cnt_d = 3'd0;
        end else begin
          busy_d    = 1'b0;
        end
      end
      START: begin
        if (end_bit_s) begin
          state_d = ADDR;
        end else begin
          state_d = START;
        end
      end
      ADDR, WRITE: begin
        if (end_bit_s) begin
          sh_d      = {sh_q[6:0], 1'b0};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_last_s) begin
            state_d = (state_q == ADDR) ? ADDR_ACK : DATA_ACK;
          end else begin
            state_d = state_q;
          end
        end else begin
          state_d = state_q;
        end
      end
      ADDR_ACK: begin
        if (sample_s && sda_in_s) begin
          ack_err_d = 1'b1;
        end else begin
          ack_err_d = ack_err_q;
        end
        // Address NACK skips the whole data phase.
        if (end_bit_s) begin
          if (ack_err_q) begin
            state_d = STOP;
          end else if (rw_q == I2C_RW_READ) begin
            state_d = READ;
            sh_d    = 8'h00;
          end else begin
            state_d = WRITE;
            sh_d    = wdata_q;
          end
        end else begin
          state_d = ADDR_ACK;
        end
      end
      READ: begin
        if (sample_s) begin
          sh_d = {sh_q[6:0], sda_in_s};
        end else begin
          sh_d = sh_q;
        end
        if (end_bit_s) begin
          bit_cnt_d = bit_cnt_q + 3'd1;
          state_d   = bit_last_s ? DATA_ACK : READ;
        end else begin
          state_d   = READ;
        end
      end
      DATA_ACK: begin
        if (sample_s && (rw_q == I2C_RW_WRITE) && sda_in_s) begin
          ack_err_d = 1'b1;
        end else begin
          ack_err_d = ack_err_q;
        end
        if (end_bit_s) begin
          state_d = STOP;
          if (rw_q == I2C_RW_READ) begin
            rdata_d = sh_q;
          end else begin
            rdata_d = rdata_q;
          end
        end else begin
          state_d = DATA_ACK;
        end
      end
      STOP: begin
        if (end_bit_s) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          state_d = STOP;
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // Decoding from next state/quarter lets the registered pulls change on the first clock of a quarter.
  assign sda_pull_d = sda_pull(state_d, quarter_nx_s, sh_d[7]);
  assign scl_pull_d = scl_pull(state_d, quarter_nx_s);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      bit_cnt_q  <= 3'd0;
      sh_q       <= 8'h00;
      rw_q       <= 1'b0;
      wdata_q    <= 8'h00;
      rdata_q    <= 8'h00;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      ack_err_q  <= 1'b0;
      sda_pull_q <= 1'b0;
      scl_pull_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      sh_q       <= sh_d;
      rw_q       <= rw_d;
      wdata_q    <= wdata_d;
      rdata_q    <= rdata_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      ack_err_q  <= ack_err_d;
      sda_pull_q <= sda_pull_d;
      scl_pull_q <= scl_pull_d;
    end
  end

  assign sda     = sda_pull_q ? 1'b0 : 1'bz;
  assign scl     = scl_pull_q ? 1'b0 : 1'bz;
  assign rdata   = rdata_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign ack_err = ack_err_q;

endmodule

// File: tb/tb_i2c_master_controller.sv
// Randomized bench for i2c_master_controller: transaction-level reference
// model feeding a scoreboard, a bus-decoding slave model and a line checker.
module tb_i2c_master_controller;

  localparam int DIV    = 4;
  localparam int T_FULL = 80 * DIV + 1;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [6:0] addr = 7'h00;
  logic       rw = 1'b0;
  logic [7:0] wdata = 8'h00;
  logic [7:0] rdata;
  logic       busy, done, ack_err;
  wire        sda_w, scl_w;
  logic       slv_pull = 1'b0;

  pullup (sda_w);
  pullup (scl_w);
  assign sda_w = slv_pull ? 1'b0 : 1'bz;

  i2c_master_controller #(.DIV(DIV)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .addr(addr), .rw(rw), .wdata(wdata),
    .rdata(rdata), .busy(busy), .done(done), .ack_err(ack_err), .sda(sda_w), .scl(scl_w)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Slave behaviour: who answers and which write bytes it refuses.
  function automatic bit slave_acks_addr(input logic [6:0] a);
    return a[3:0] != 4'h1;
  endfunction
  function automatic bit slave_acks_data(input logic [7:0] d);
    return d[7:4] != 4'hF;
  endfunction

  typedef struct {
    int         done_c;
    logic       ack_err;
    logic [7:0] rdata;
    logic [7:0] abyte;
    logic [7:0] dbyte;
    logic       rd;
    logic       aok;
    int         rises;
  } exp_t;

  exp_t       exp_q[$];
  int         cyc = 0;
  int         free_from = 0;
  int         cur_acc = -10;
  int         cur_done = -10;
  int         n_acc = 0;
  logic [7:0] m_rdata = 8'h00;
  logic [7:0] drv_rd = 8'h00;
  logic [7:0] slv_rd = 8'h00;

  // Reference model: decides acceptance and predicts each transaction's outcome.
  always @(posedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      m_rdata   = 8'h00;
      cur_acc   = -10;
      cur_done  = -10;
      free_from = 0;
    end else if (start && cyc >= free_from) begin
      exp_t e;
      e.aok     = slave_acks_addr(addr);
      e.rd      = rw;
      e.abyte   = {addr, rw};
      e.dbyte   = rw ? drv_rd : wdata;
      e.ack_err = !e.aok || (!rw && !slave_acks_data(wdata));
      if (e.aok && rw) m_rdata = drv_rd;
      e.rdata   = m_rdata;
      e.done_c  = cyc + (e.aok ? 80 * DIV : 44 * DIV) + 1;
      e.rises   = e.aok ? 19 : 10;
      cur_acc   = cyc;
      cur_done  = e.done_c;
      free_from = e.done_c + 1;
      slv_rd    = drv_rd;
      n_acc++;
      exp_q.push_back(e);
    end
    cyc++;
  end

  logic       scl_p = 1'b1, sda_p = 1'b1;
  int         bitn = 0;
  int         rises = 0;
  bit         active = 1'b0, s_aok = 1'b0, s_rd = 1'b0;
  logic [7:0] obs_a = 8'h00, obs_d = 8'h00;
  logic       obs_mack = 1'b0;

  // Slave model plus line checker, decoding the bus from SCL/SDA edges.
  always @(negedge clk) begin
    if (!rst_n) begin
      active   = 1'b0;
      slv_pull = 1'b0;
      bitn     = 0;
    end else begin
      if (slv_pull) check("sda_wired_and", sda_w, 1'b0);
      if (scl_p && scl_w && sda_p && !sda_w) begin
        check("start_when_idle", active, 1'b0);
        active = 1'b1; bitn = 0; rises = 0; s_aok = 1'b0;
        obs_a = 8'h00; obs_d = 8'h00;
      end else if (scl_p && scl_w && !sda_p && sda_w) begin
        check("stop_when_active", active, 1'b1);
        active = 1'b0; slv_pull = 1'b0;
      end else if (!scl_p && scl_w) begin
        rises++;
        if (bitn < 8) obs_a = {obs_a[6:0], sda_w};
        else if (bitn >= 9 && bitn <= 16) obs_d = {obs_d[6:0], sda_w};
        else if (bitn == 17) obs_mack = sda_w;
        bitn++;
      end else if (scl_p && !scl_w) begin
        slv_pull = 1'b0;
        if (active && bitn == 8 && slave_acks_addr(obs_a[7:1])) begin
          s_aok = 1'b1; s_rd = obs_a[0]; slv_pull = 1'b1;
        end else if (active && s_aok && s_rd && bitn >= 9 && bitn <= 16) begin
          slv_pull = !slv_rd[16 - bitn];
        end else if (active && s_aok && !s_rd && bitn == 17 && slave_acks_data(obs_d)) begin
          slv_pull = 1'b1;
        end
      end
    end
    scl_p = scl_w;
    sda_p = sda_w;
  end

  // Scoreboard monitor: busy window every cycle, full result on each done pulse.
  always @(negedge clk) begin
    if (rst_n) begin
      check("busy", busy, (cyc > cur_acc) && (cyc < cur_done));
      if (done) begin
        if (exp_q.size() == 0) begin
          check("unexpected_done", 1'b1, 1'b0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("done_cycle", cyc, e.done_c);
          check("ack_err", ack_err, e.ack_err);
          check("rdata", rdata, e.rdata);
          check("bus_addr_byte", obs_a, e.abyte);
          check("scl_rises", rises, e.rises);
          check("stop_seen", active, 1'b0);
          if (e.aok) check("bus_data_byte", obs_d, e.dbyte);
          if (e.aok && e.rd) check("read_nack", obs_mack, 1'b1);
        end
      end else if (exp_q.size() > 0 && cyc > exp_q[0].done_c) begin
        check("done_timeout", 1'b0, 1'b1);
        void'(exp_q.pop_front());
      end
    end
  end

  task automatic do_txn(input logic [6:0] a, input logic r, input logic [7:0] wd,
                        input logic [7:0] rb);
    int na;
    na     = n_acc;
    addr   = a; rw = r; wdata = wd; drv_rd = rb;
    start  = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (n_acc != na) break;
    end
    start = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 3 * T_FULL) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) check("idle_timeout", exp_q.size(), 0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_ack_err", ack_err, 1'b0);
    check("rst_rdata", rdata, 8'h00);
    check("rst_sda", sda_w, 1'b1);
    check("rst_scl", scl_w, 1'b1);
    rst_n = 1'b1;
    @(negedge clk);

    do_txn(7'h2A, 1'b0, 8'hA5, 8'h00); wait_idle();
    do_txn(7'h2A, 1'b1, 8'h00, 8'hCC); wait_idle();
    do_txn(7'h11, 1'b0, 8'h5A, 8'h00); wait_idle();
    repeat (3) @(negedge clk);

    // start held high across two transactions; busy-time input changes are ignored
    addr = 7'h2A; rw = 1'b0; wdata = 8'h3C; drv_rd = 8'h00;
    start = 1'b1;
    for (int i = 0; i < 2 * T_FULL; i++) begin
      @(negedge clk);
      if (i == T_FULL / 2) wdata = 8'($urandom);
    end
    start = 1'b0;
    wait_idle();
    repeat (2) @(negedge clk);

    // reset during address bit 3
    do_txn(7'h2A, 1'b1, 8'h00, 8'h96);
    repeat (17 * DIV) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_sda", sda_w, 1'b1);
    check("midrst_scl", scl_w, 1'b1);
    check("midrst_busy", busy, 1'b0);
    check("midrst_rdata", rdata, 8'h00);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    do_txn(7'h2A, 1'b0, 8'h81, 8'h00); wait_idle();

    for (int t = 0; t < 14; t++) begin
      logic [6:0] a;
      int sel;
      sel = int'($urandom_range(0, 3));
      a   = (sel == 0) ? 7'h2A : (sel == 1) ? 7'h11 : 7'($urandom);
      repeat ($urandom_range(0, 3)) @(negedge clk);
      do_txn(a, 1'($urandom), 8'($urandom), 8'($urandom));
      wait_idle();
    end
    repeat (4) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

endmodule
